// File: rtl/bridge_uart_rx.sv
// UART receiver for the bridge link: synchronizes rx, frames start/data/stop bits
// LSB first, and presents each good word through a one-deep valid/ready holding register.
module bridge_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                state_q;
  logic                  rx_meta_q;
  logic                  rxs_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  frame_error_q;
  logic                  overrun_q;
  logic                  handshake_d;

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q + 1'b1;
    handshake_d = data_valid_q & data_ready;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rxs_q         <= rx_meta_q;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;

      // A frame completing in this cycle overrides this clear further down.
      if (handshake_d) begin
        data_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == HALF_END) begin
            cnt_q <= '0;
            if (!rxs_q) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DATA: begin
          if (cnt_q == BIT_END) begin
            shift_q[idx_q] <= rxs_q;
            cnt_q          <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_d;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              // Accept into an empty register or one being drained this same cycle.
              if (!data_valid_q || data_ready) begin
                data_out_q   <= shift_q;
                data_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        WAIT_IDLE: begin
          if (rxs_q) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bridge_uart_rx.sv
// Self-checking bench for bridge_uart_rx at 4 clocks per bit, 8 data bits.
// Frames are serialized cycle by cycle so handshakes and resets land on exact bit positions.
module tb_bridge_uart_rx;
  localparam int CPB = 4;
  localparam int DW  = 8;
  // Stop-bit decision lands this many clocks after the start bit is driven low.
  localparam int STOP_LATENCY = (DW + 1) * CPB + 5;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          data_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_error;
  logic          overrun;
  logic          busy;

  bridge_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clock      (clock),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int rise_cyc = -1;
  int frame_start_cyc = 0;
  logic prev_valid = 1'b0;

  // Pulse and event monitor, sampled just after each rising edge.
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    if (frame_error) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if (data_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = data_valid;
  end

  // Serialize one frame; ready_at / rst_at pulse those inputs for one clock at that offset.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_after,
                            input int ready_at, input int rst_at);
    frame_start_cyc = cyc;
    $display("tx frame data=%02h stop=%0b idle=%0d start_cycle=%0d", d, stop, idle_after, cyc);
    for (int t = 0; t < (DW + 2) * CPB + idle_after; t++) begin
      int   b;
      logic v;
      b = t / CPB;
      if (b == 0) v = 1'b0;
      else if (b <= DW) v = d[b-1];
      else if (b == DW + 1) v = stop;
      else v = 1'b1;
      rx = v;
      data_ready = (t == ready_at);
      rst = (t == rst_at);
      @(negedge clock);
    end
    data_ready = 1'b0;
    rst = 1'b0;
    rx = 1'b1;
  endtask

  task automatic consume();
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    n_checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_flags got fe=%b ov=%b exp 0 0", frame_error, overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    data_ready = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_single();
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 4, -1, -1);
    n_checks++; if (rise_cyc - frame_start_cyc !== STOP_LATENCY) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", rise_cyc - frame_start_cyc, STOP_LATENCY); end
    n_checks++; if (data_out !== 8'hA5 || data_valid !== 1'b1) begin n_fail++; $display("FAIL single_data got=%h/%b exp=a5/1", data_out, data_valid); end
    repeat (10) @(negedge clock);
    n_checks++; if (data_out !== 8'hA5 || data_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold got=%h/%b exp=a5/1", data_out, data_valid); end
    consume();
    n_checks++; if (data_valid !== 1'b0 || data_out !== 8'hA5) begin n_fail++; $display("FAIL single_consume got=%h/%b exp=a5/0", data_out, data_valid); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1, 0, -1, -1);
    send_frame(8'h81, 1'b1, 4, -1, -1);
    n_checks++; if (data_out !== 8'h3C || data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_data got=%h/%b exp=3c/1", data_out, data_valid); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt - ov0); end
    consume();
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 0, -1, -1);
    rx = 1'b0;
    repeat (20) @(negedge clock);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low got=%b exp=1", busy); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - fe0); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got=%b exp=0", data_valid); end
    rx = 1'b1;
    repeat (8) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
    n_checks++; if (fe_cnt - fe0 !== 1 || data_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_no_second got fe=%0d valid=%b exp 1 0", fe_cnt - fe0, data_valid); end
  endtask

  task automatic test_glitch();
    int b0;
    int fe0;
    b0 = busy_cnt;
    fe0 = fe_cnt;
    $display("tx glitch rx low one clock at cycle %0d", cyc);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (10) @(negedge clock);
    n_checks++; if (busy_cnt - b0 < 1 || busy_cnt - b0 >= CPB) begin n_fail++; $display("FAIL glitch_busy_cycles got=%0d exp 1..%0d", busy_cnt - b0, CPB - 1); end
    n_checks++; if (busy !== 1'b0 || data_valid !== 1'b0 || fe_cnt !== fe0) begin n_fail++; $display("FAIL glitch_idle got busy=%b valid=%b fe=%0d exp 0 0 0", busy, data_valid, fe_cnt - fe0); end
  endtask

  task automatic test_handshake_complete();
    int ov0;
    send_frame(8'h01, 1'b1, 4, -1, -1);
    n_checks++; if (data_out !== 8'h01 || data_valid !== 1'b1) begin n_fail++; $display("FAIL hs_first got=%h/%b exp=01/1", data_out, data_valid); end
    ov0 = ov_cnt;
    send_frame(8'h02, 1'b1, 4, STOP_LATENCY - 1, -1);
    n_checks++; if (data_out !== 8'h02 || data_valid !== 1'b1) begin n_fail++; $display("FAIL hs_replace got=%h/%b exp=02/1", data_out, data_valid); end
    n_checks++; if (ov_cnt !== ov0) begin n_fail++; $display("FAIL hs_no_overrun got=%0d exp=0", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    // Reset with a simultaneous handshake during data bit 4 of 0xFF.
    send_frame(8'hFF, 1'b1, 4, 5 * CPB + 2, 5 * CPB + 2);
    n_checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got=%h/%b exp=00/0", data_out, data_valid); end
    n_checks++; if (busy !== 1'b0 || fe_cnt !== fe0 || ov_cnt !== ov0) begin n_fail++; $display("FAIL midrst_flags got busy=%b fe=%0d ov=%0d exp 0 0 0", busy, fe_cnt - fe0, ov_cnt - ov0); end
    send_frame(8'h12, 1'b1, 4, -1, -1);
    n_checks++; if (data_out !== 8'h12 || data_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next got=%h/%b exp=12/1", data_out, data_valid); end
    consume();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] model_data;
    logic       model_valid;
    int         model_ov;
    int         n;
    int         ov0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, $urandom_range(2, 6), -1, -1);
      n_checks++; if (data_out !== b || data_valid !== 1'b1) begin n_fail++; $display("FAIL rand_single got=%h/%b exp=%h/1", data_out, data_valid, b); end
      consume();
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rand_consume got=%b exp=0", data_valid); end
    end
    // Burst with no consumer: only the first word is kept, the rest overrun.
    n = $urandom_range(2, 4);
    model_valid = 1'b0;
    model_data = 8'h00;
    model_ov = 0;
    ov0 = ov_cnt;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, (i == n - 1) ? 4 : $urandom_range(0, 3), -1, -1);
      if (!model_valid) begin
        model_data = b;
        model_valid = 1'b1;
      end else begin
        model_ov++;
      end
    end
    n_checks++; if (data_out !== model_data || data_valid !== model_valid) begin n_fail++; $display("FAIL rand_burst_data got=%h/%b exp=%h/%b", data_out, data_valid, model_data, model_valid); end
    n_checks++; if (ov_cnt - ov0 !== model_ov) begin n_fail++; $display("FAIL rand_burst_overrun got=%0d exp=%0d", ov_cnt - ov0, model_ov); end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_handshake_complete();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_uart_rx.md
BRIDGE_UART_RX -- requirements
Module: bridge_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200); legal values are 4 or more.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data bits per frame.
REQ-003 SHALL have port clock, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rx, input, 1 bit: serial line, asynchronous to clock, idle high; connects to a peer bridge's uart_tx.
REQ-006 SHALL have port data_out, output, DATA_WIDTH bits: received word held in the holding register.
REQ-007 SHALL have port data_valid, output, 1 bit: holding register contains an unconsumed word.
REQ-008 SHALL have port data_ready, input, 1 bit: consumer accepts data_out in any cycle where data_valid=1 and data_ready=1.
REQ-009 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good frame is dropped because the holding register is full.
REQ-011 SHALL have port busy, output, 1 bit: high in every FSM state except IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer, with both flops reset to 1; all FSM decisions use the synchronized value rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP and WAIT_IDLE, plus a bit-time counter and a bit index sized for CLKS_PER_BIT-1 and DATA_WIDTH-1.
REQ-014 IDLE: when rxs=0, SHALL clear the counter and move to START.
REQ-015 START: at counter=(CLKS_PER_BIT/2)-1, SHALL re-sample rxs; if 0, clear the counter, set bit index to 0 and move to DATA; if 1 (glitch), move to IDLE with no flag.
REQ-016 DATA: at each counter=CLKS_PER_BIT-1, SHALL sample rxs into shift-register bit [index], LSB first, and clear the counter; after bit DATA_WIDTH-1, move to STOP.
REQ-017 STOP: at counter=CLKS_PER_BIT-1, SHALL sample rxs; if 1, complete the frame per REQ-019 to REQ-021 and move to IDLE; if 0, pulse frame_error, discard the word and move to WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL remain until rxs=1 (break or line stuck low), then move to IDLE; it SHALL NOT start a new frame while rxs stays low.
REQ-019 On a good frame completion with data_valid=0, SHALL load data_out and set data_valid=1 in the next cycle.
REQ-020 On a good frame completion with data_valid=1 and data_ready=0, SHALL keep the old data_out and data_valid=1, drop the new word and pulse overrun.
REQ-021 On a good frame completion in the same cycle as a handshake (data_valid=1, data_ready=1), SHALL load the new word, keep data_valid=1 and not pulse overrun.
REQ-022 On a handshake with no frame completion in that cycle, SHALL clear data_valid next cycle; data_out SHALL hold its last value.
REQ-023 data_out SHALL be stable while data_valid=1 and no handshake occurs.
REQ-024 Latency: data_valid SHALL rise 1 cycle after the stop-bit sample; the stop-bit sample falls about (DATA_WIDTH+1.5) x CLKS_PER_BIT + 3 cycles after the rx falling edge.
REQ-025 The counter and bit index SHALL wrap cleanly and never exceed their terminal values; data_ready while data_valid=0 SHALL be ignored.

Reset
REQ-026 With rst=1 at a clock edge, SHALL set the FSM to IDLE, counters to 0, synchronizer to 1, data_out=0, data_valid=0, frame_error=0, overrun=0 and busy=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no flags; after reset, the first low rxs SHALL be treated as a new start bit.
REQ-028 rst SHALL take priority over all other inputs, including a handshake in the same cycle.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-029 Send 0xA5 with start, 8 data bits and stop, data_ready=0 -> data_out=0xA5, data_valid=1, held until data_ready=1, then data_valid=0 next cycle.
REQ-030 Send 0x3C then 0x81 back-to-back, data_ready=0 -> data_out=0x3C, one overrun pulse at the 0x81 stop sample, data_valid still 1.
REQ-031 Send 0x55 with stop bit 0, then hold rx low 20 cycles, then high -> one frame_error pulse, data_valid=0, busy=1 until rx high, no second frame.
REQ-032 Pulse rx low for 1 bit-time/4 (1 cycle) -> FSM returns to IDLE, no data_valid, no frame_error.
REQ-033 Assert rst for 1 cycle during bit 4 of 0xFF, then send 0x12 -> all outputs 0 after reset, then data_out=0x12, data_valid=1.
REQ-034 With 0x01 held and data_ready=1 in the cycle 0x02 completes -> data_out=0x02, data_valid stays 1, no overrun.
